rc4_ksa_controller: RTL
=======================

Name: rc4_ksa_controller

Overview:
- Sequences the RC4 key-scheduling algorithm (KSA) over the 256-byte S working memory.
- Steps i from 0 to 255. Selects key byte key[i mod KEY_LEN] with a rolling index counter rather than a divider. Accumulates j and swaps S[i] and S[j].
- Sits between the cracking engine's key generator (start/done handshake) and the single-port S memory. The memory is already identity-initialised when start arrives.

Parameters:
- KEY_LEN, 3, key length in bytes. The key port is 8*KEY_LEN wide. Byte 0 is the most significant byte.

Ports:
- clk  in  1  system clock, all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level; sampled only in IDLE.
- secret_key  in  8*KEY_LEN  key; latched on the start-accept cycle.
- busy  out  1  high while a KSA pass is in progress.
- done  out  1  one-cycle pulse at the end of a pass.
- s_addr  out  8  S memory address.
- s_wdata  out  8  S memory write data.
- s_wren  out  1  S memory write enable.
- s_rdata  in  8  S memory read data. Valid in the cycle after the address is presented with s_wren=0.

Behaviour:
- Reset (async assert, sync-release assumed upstream):
  - state=IDLE.
  - i, j, key index k, latched key, si, sj all 0.
  - busy=0, done=0, s_addr=0, s_wdata=0, s_wren=0.
- Registered outputs: s_addr, s_wdata, s_wren, busy and done are all registered.
- Start accept:
  - Condition: IDLE with start=1.
  - Latches the key; sets i=0, j=0, k=0.
  - Goes to RD_I with busy=1 on the next cycle.
  - start is ignored in all other states. Key changes after accept have no effect.
- Per-iteration states (6 cycles each):
  - RD_I: s_addr=i, s_wren=0.
  - LAT_I: si<=s_rdata; j<=(j + s_rdata + keybyte(k)) mod 256, with 8-bit wrap.
  - RD_J: s_addr=j (the updated value), s_wren=0.
  - LAT_J: sj<=s_rdata.
  - WR_I: s_addr=i, s_wdata=sj, s_wren=1.
  - WR_J: s_addr=j, s_wdata=si, s_wren=1.
    - If i==255, go to DONE.
    - Otherwise i<=i+1, k<=(k==KEY_LEN-1)?0:k+1, and go to RD_I.
- s_wren is high only in WR_I and WR_J.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
  - A start held high in DONE is not accepted until IDLE, so the earliest restart is accepted in the cycle after DONE.
- Latency: start sampled at edge E0.
  - First RD_I address is presented after E0.
  - 256×6 = 1536 busy cycles.
  - done is high in cycle 1537.
- Key byte mapping: keybyte(0)=key[8*KEY_LEN-1 -: 8], keybyte(1) is the next lower byte, and so on. At i=255 with KEY_LEN=3, k=0.
- i==j: both writes hit the same address with the same value. No special casing; S is unchanged.
- j wrap: the 8-bit add truncates silently. No overflow flag.
- Reset mid-pass: returns to IDLE immediately, with s_wren=0 asynchronously. S contents are undefined, and the requester must re-initialise S.

Test Plan:
- Reset and idle:
  - Assert rst_n=0 mid-pass (during WR_I, iteration 40) → s_wren, busy and done go 0 without waiting for a clock edge.
  - After release, no memory access occurs until start.
- Key byte order:
  - Stimulus: identity S, key 24'h010203.
  - Required write pairs in order:
    - i=0: (addr0←1, addr1←0)
    - i=1: (addr1←3, addr3←0)
    - i=2: (addr2←8, addr8←2)
    - i=3: j=9, so (addr3←9, addr9←0).
- Swap with i==j:
  - Stimulus: identity S, key 24'h000000.
  - i=0 and i=1 write back unchanged values (addr0←0 twice, addr1←1 twice).
  - i=2: j=3, giving addr2←3, addr3←2.
- Full pass and timing:
  - Stimulus: key 24'hA5F00F.
  - Final S matches a behavioural RC4 KSA model byte-for-byte.
  - busy is high for exactly 1536 cycles; done is a single pulse in cycle 1537.
  - Exactly 512 write cycles occur.
- Handshake robustness:
  - Toggle start and change secret_key during a pass → no effect on the sequence or result.
  - Hold start high through DONE → second pass is accepted in the cycle after DONE, with j and k restarted at 0.
- Parameter:
  - Stimulus: KEY_LEN=5, key 40'h0102030405, identity S.
  - k cycles 0..4. i=0 gives j=1; i=5 uses byte 0x01 again. Final S matches the model.

Source files
------------

// File: rtl/rc4_ksa_controller.sv
// RC4 key-scheduling sequencer driving a single-port S memory with one-cycle
// registered reads. Each of the 256 iterations takes six cycles:
// read S[i], accumulate j, read S[j], then write the swapped pair back.
module rc4_ksa_controller #(
    parameter int KEY_LEN = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [8*KEY_LEN-1:0]   secret_key,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             s_addr,
    output logic [7:0]             s_wdata,
    output logic                   s_wren,
    input  logic [7:0]             s_rdata
);

    localparam int KW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_I,
        LAT_I,
        RD_J,
        LAT_J,
        WR_I,
        WR_J,
        DONE
    } state_t;

    state_t               state_reg;
    logic [7:0]           i_reg;
    logic [7:0]           j_reg;
    logic [7:0]           si_reg;
    logic [KW-1:0]        k_reg;
    logic [8*KEY_LEN-1:0] key_reg;

    logic [7:0]           key_bytes [KEY_LEN];
    logic [7:0]           key_byte;
    logic [7:0]           j_next;
    logic                 k_last;

    // Split the latched key into bytes, byte 0 being the most significant.
    generate
        for (genvar gi = 0; gi < KEY_LEN; gi++) begin : g_key_bytes
            assign key_bytes[gi] = key_reg[8*(KEY_LEN-gi)-1 -: 8];
        end
    endgenerate

    // Rolling key index replaces i mod KEY_LEN; the j sum wraps at 8 bits.
    assign key_byte = key_bytes[k_reg];
    assign j_next   = j_reg + s_rdata + key_byte;
    assign k_last   = (k_reg == KW'(KEY_LEN - 1));

    // Sequencer: every memory-facing output is registered and set on entry
    // to the state that uses it. s_wdata captures S[j] straight from the
    // read port in LAT_J, so it serves as the sj holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            i_reg     <= 8'd0;
            j_reg     <= 8'd0;
            k_reg     <= '0;
            key_reg   <= '0;
            si_reg    <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            s_addr    <= 8'd0;
            s_wdata   <= 8'd0;
            s_wren    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        key_reg   <= secret_key;
                        i_reg     <= 8'd0;
                        j_reg     <= 8'd0;
                        k_reg     <= '0;
                        s_addr    <= 8'd0;
                        s_wren    <= 1'b0;
                        busy      <= 1'b1;
                        state_reg <= RD_I;
                    end
                end
                RD_I: begin
                    state_reg <= LAT_I;
                end
                LAT_I: begin
                    si_reg    <= s_rdata;
                    j_reg     <= j_next;
                    s_addr    <= j_next;
                    state_reg <= RD_J;
                end
                RD_J: begin
                    state_reg <= LAT_J;
                end
                LAT_J: begin
                    s_addr    <= i_reg;
                    s_wdata   <= s_rdata;
                    s_wren    <= 1'b1;
                    state_reg <= WR_I;
                end
                WR_I: begin
                    s_addr    <= j_reg;
                    s_wdata   <= si_reg;
                    s_wren    <= 1'b1;
                    state_reg <= WR_J;
                end
                WR_J: begin
                    s_wren <= 1'b0;
                    if (i_reg == 8'd255) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        i_reg     <= i_reg + 8'd1;
                        k_reg     <= k_last ? '0 : k_reg + 1'b1;
                        s_addr    <= i_reg + 8'd1;
                        state_reg <= RD_I;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
